// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter/sequencer sharing one UART_TX between NREQ byte
//   producers. Accepts one byte at a time, launches it with a single tx_en
//   pulse, then waits for UART_TX to go busy and idle again before granting
//   the next byte. Never launches while tx_state is high.
//
// Ports
//   clk, RSTn     clock, asynchronous active-low reset
//   req_valid     per-requester byte available
//   req_data      requester i byte at [8*i+7:8*i]
//   req_lock      (UART_ARB_LOCK_EN only) keep the grant on this requester
//   req_ready     one-hot accept pulse (transfer = valid & ready)
//   tx_data       byte presented to UART_TX, held until the next grant
//   tx_en         single-cycle launch pulse to UART_TX
//   tx_state      UART_TX busy flag
//   grant_id      requester owning the current/last transfer
//   busy          FSM not idle
//   timeout_err   pulse when tx_state fails to rise within START_TO cycles
//
// Optional feature: define UART_ARB_LOCK_EN to add req_lock (message lock).

module uart_tx_arbiter #(
   parameter int NREQ     = 4,
   parameter int ID_W     = 2,
   parameter int START_TO = 1024
) (
   input  logic              clk,
   input  logic              RSTn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
   input  logic [NREQ-1:0]   req_lock,
`endif
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_en,
   input  logic              tx_state,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr;
   logic [15:0]     cnt, cnt_nxt;
   logic [ID_W-1:0] rr_sel, sel;
   logic            rr_found, found, lock_hit, grant;
   logic [ID_W:0]   sum;
   logic [7:0]      sel_data;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      rr_sel   = '0;
      rr_found = 1'b0;
      sum      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NREQ))
            sum = sum - (ID_W+1)'(NREQ);
         if (!rr_found && req_valid[sum[ID_W-1:0]]) begin
            rr_found = 1'b1;
            rr_sel   = sum[ID_W-1:0];
         end
      end
   end

`ifdef UART_ARB_LOCK_EN
   // Lock privilege is only offered in the first IDLE cycle after a frame
   // completed normally; a timeout path never sets it.
   logic lock_ok;

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) lock_ok <= 1'b0;
      else       lock_ok <= (state == WAIT_DONE) && !tx_state;
   end

   assign lock_hit = lock_ok && req_lock[grant_id] && req_valid[grant_id];
`else
   assign lock_hit = 1'b0;
`endif

   assign sel   = lock_hit ? grant_id : rr_sel;
   assign found = lock_hit | rr_found;

   // RSTn gating keeps req_ready low while reset is held, even in IDLE.
   assign grant     = RSTn && (state == IDLE) && !tx_state && found;
   assign req_ready = grant ? (NREQ'(1) << sel) : '0;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (sel == ID_W'(i)) sel_data = req_data[8*i +: 8];
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tx_en       = 1'b0;
      timeout_err = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE:
            if (grant) state_nxt = LAUNCH;
         LAUNCH: begin
            tx_en     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_START;
         end
         WAIT_START:
            if (tx_state)
               state_nxt = WAIT_DONE;
            else if (cnt == 16'(START_TO - 1)) begin
               // byte is dropped, pointer stays advanced
               timeout_err = 1'b1;
               state_nxt   = IDLE;
            end else
               cnt_nxt = cnt + 16'd1;
         WAIT_DONE:
            if (!tx_state) state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr      <= ID_W'(NREQ - 1);
         tx_data  <= '0;
         grant_id <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (grant) begin
            tx_data  <= sel_data;
            grant_id <= sel;
            ptr      <= sel;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int NREQ     = 4;
   localparam int ID_W     = 2;
   localparam int START_TO = 16;

   logic              clk;
   logic              RSTn;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_data;
   logic              tx_en;
   logic              tx_state;
   logic [ID_W-1:0]   grant_id;
   logic              busy;
   logic              timeout_err;
   logic              uart_busy, tx_force;
`ifdef UART_ARB_LOCK_EN
   logic [NREQ-1:0]   req_lock;
`endif

   assign tx_state = uart_busy | tx_force;

   uart_tx_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .START_TO(START_TO)) dut (
      .clk(clk), .RSTn(RSTn), .req_valid(req_valid), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en),
      .tx_state(tx_state), .grant_id(grant_id), .busy(busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // requester byte queues (head/tail indices into fixed buffers)
   logic [7:0] rbuf [NREQ][32];
   int         rhd [NREQ];
   int         rtl [NREQ];

   // reference model state
   int         mptr;
   int         m_last;
   bit         m_lock_ok;
   logic [7:0] exp_q [$];
   logic [7:0] log_q [$];
   int         ghist [$];
   int         n_grant = 0, n_txen = 0;
   int         uart_mode = 0;   // 0: UART responds, 1: UART ignores tx_en
   int         frame_len = 100;

   // values sampled at the last negedge
   logic [NREQ-1:0] s_ready;
   logic [7:0]      s_txdata;
   logic [ID_W-1:0] s_gid;
   logic            s_txen, s_busy, s_txst, s_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pending(input int i);
      return rhd[i] < rtl[i];
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++) if (pending(i)) return 1'b0;
      return 1'b1;
   endfunction

   // Who should win now: lock holder if privileged, else first pending after mptr.
   function automatic int model_pick();
`ifdef UART_ARB_LOCK_EN
      if (m_lock_ok && req_lock[m_last] && pending(m_last)) return m_last;
`endif
      for (int k = 1; k <= NREQ; k++)
         if (pending((mptr + k) % NREQ)) return (mptr + k) % NREQ;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = pending(i);
         req_data[8*i +: 8] = pending(i) ? rbuf[i][rhd[i]] : 8'h00;
      end
   endtask

   task automatic load(input int r, input logic [7:0] b);
      rbuf[r][rtl[r]] = b;
      rtl[r]++;
   endtask

   task automatic model_reset();
      mptr      = NREQ - 1;
      m_last    = 0;
      m_lock_ok = 1'b0;
   endtask

   // One clock: sample at negedge, check any grant against the model,
   // then update the requesters just after the edge.
   task automatic step();
      int w, a;
      a = -1;
      @(negedge clk);
      s_ready = req_ready; s_txen = tx_en; s_txdata = tx_data; s_gid = grant_id;
      s_busy = busy; s_txst = tx_state; s_to = timeout_err;
      if (RSTn === 1'b1 && req_ready != '0) begin
         w = model_pick();
         chk("grant_onehot", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
         for (int i = 0; i < NREQ; i++) if (req_ready[i] && a < 0) a = i;
         if (pending(a)) exp_q.push_back(rbuf[a][rhd[a]]);
         mptr = a; m_last = a; m_lock_ok = (uart_mode == 0);
         ghist.push_back(a);
         n_grant++;
      end
      @(posedge clk);
      #1;
      if (a >= 0 && pending(a)) rhd[a]++;
      drive();
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (!(all_empty() && busy === 1'b0 && tx_state === 1'b0) && n < 6000) begin
         step();
         n++;
      end
      chk({tag, "_drain_bound"}, 32'(n < 6000), 32'd1);
      chk({tag, "_txen_count"}, n_txen, n_grant);
      while (exp_q.size() > 0 && log_q.size() > 0)
         chk({tag, "_byte"}, 32'(log_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_left"}, exp_q.size() + log_q.size(), 0);
      for (int i = 0; i < NREQ; i++) begin rhd[i] = 0; rtl[i] = 0; end
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 RSTn = 1'b1;
   endtask

   // launch monitor: every tx_en must find UART_TX idle
   initial forever begin
      @(negedge clk);
      if (RSTn === 1'b1 && tx_en === 1'b1) begin
         chk("launch_while_busy", 32'(tx_state), 32'd0);
         log_q.push_back(tx_data);
         n_txen++;
      end
   end

   // UART_TX model: busy 3 cycles after tx_en, for frame_len cycles
   initial begin
      uart_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (RSTn === 1'b1 && tx_en === 1'b1 && uart_mode == 0) begin
            repeat (3) @(posedge clk);
            #2 uart_busy = 1'b1;
            repeat (frame_len) @(posedge clk);
            #2 uart_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, g0;
      int expg [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NREQ; i++) begin rhd[i] = 0; rtl[i] = 0; end
      tx_force = 1'b0;
`ifdef UART_ARB_LOCK_EN
      req_lock = '0;
`endif
      model_reset();

      // reset state, with all requesters shouting
      RSTn      = 1'b0;
      req_valid = '1;
      req_data  = 32'h13121110;
      @(negedge clk);
      chk("reset_outputs", 32'({req_ready, tx_data, tx_en, grant_id, busy, timeout_err}), 32'd0);
      drive();
      @(posedge clk);
      #1 RSTn = 1'b1;

      // single byte A5 from requester 0, 100-cycle frame
      frame_len = 100;
      load(0, 8'hA5); drive();
      step();
      chk("t1_ready", 32'(s_ready), 32'h1);
      chk("t1_no_en", 32'(s_txen), 32'd0);
      step();
      chk("t1_ready_1cyc", 32'(s_ready), 32'd0);
      chk("t1_tx_en", 32'(s_txen), 32'd1);
      chk("t1_tx_data", 32'(s_txdata), 32'hA5);
      chk("t1_grant_id", 32'(s_gid), 32'd0);
      step();
      chk("t1_en_1cyc", 32'(s_txen), 32'd0);
      n = 0; while (s_txst !== 1'b1 && n < 50) begin step(); n++; end
      chk("t1_start_seen", 32'(s_txst), 32'd1);
      n = 0; while (s_txst !== 1'b0 && n < 300) begin step(); n++; end
      chk("t1_busy_hold", 32'(s_busy), 32'd1);
      step();
      chk("t1_busy_fall", 32'(s_busy), 32'd0);
      drain("t1");

      // all four valid: rotation 0,1,2,3,0
      frame_len = 20;
      do_reset();
      ghist.delete();
      load(0, 8'h10); load(0, 8'h10); load(1, 8'h11); load(2, 8'h12); load(3, 8'h13);
      drive();
      drain("rr");
      chk("rr_count", ghist.size(), 5);
      for (int i = 0; i < 5 && i < ghist.size(); i++) chk("rr_order", ghist[i], expg[i]);

      // timeout: UART never goes busy
      do_reset();
      ghist.delete();
      uart_mode = 1;
      load(0, 8'h55); load(1, 8'h66); drive();
      n = 0; while (s_ready == '0 && n < 10) begin step(); n++; end
      chk("to_first_grant", 32'(s_ready), 32'h1);
      for (int k = 0; k <= 16; k++) begin
         step();
         if (k == 0) chk("to_launch", 32'(s_txen), 32'd1);
         chk("to_pulse", 32'(s_to), 32'(k == 16));
      end
      uart_mode = 0;
      m_lock_ok = 1'b0;
      drain("to");
      chk("to_count", ghist.size(), 2);
      if (ghist.size() == 2) chk("to_next_req", ghist[1], 1);

      // tx_state held high in IDLE blocks requester 2
      ghist.delete();
      tx_force = 1'b1;
      load(2, 8'h77); drive();
      for (int k = 0; k < 8; k++) begin
         step();
         chk("blocked", 32'({s_ready, s_txen}), 32'd0);
      end
      tx_force = 1'b0;
      drain("blk");
      chk("blk_grant_id", 32'(grant_id), 32'd2);

      // reset during WAIT_DONE, then 0 beats 3
      load(1, 8'h31); drive();
      n = 0; while (s_txst !== 1'b1 && n < 20) begin step(); n++; end
      repeat (3) step();
      chk("rst_in_wait_done", 32'({busy, tx_state}), 32'h3);
      load(0, 8'h21); load(3, 8'h24); drive();
      #2 RSTn = 1'b0;
      model_reset();
      #1;
      chk("async_reset", 32'({req_ready, tx_data, tx_en, grant_id, busy, timeout_err}), 32'd0);
      @(posedge clk); @(posedge clk);
      #1 RSTn = 1'b1;
      ghist.delete();
      drain("rst");
      chk("rst_count", ghist.size(), 2);
      if (ghist.size() == 2) begin
         chk("rst_first", ghist[0], 0);
         chk("rst_second", ghist[1], 3);
      end

`ifdef UART_ARB_LOCK_EN
      // locked requester 1 sends three bytes back to back
      do_reset();
      ghist.delete();
      req_lock = 4'b0010;
      load(1, 8'h01); load(1, 8'h02); load(1, 8'h03); load(2, 8'h09); drive();
      drain("lock");
      chk("lock_count", ghist.size(), 4);
      if (ghist.size() == 4) begin
         chk("lock_g0", ghist[0], 1); chk("lock_g1", ghist[1], 1);
         chk("lock_g2", ghist[2], 1); chk("lock_g3", ghist[3], 2);
      end
      req_lock = '0;
`endif

      // randomized rounds against the model
      for (int r = 0; r < 6; r++) begin
         frame_len = $urandom_range(4, 30);
         for (int i = 0; i < NREQ; i++) begin
            g0 = $urandom_range(0, 3);
            for (int j = 0; j < g0; j++) load(i, 8'($urandom));
         end
         drive();
         drain("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single UART_TX transmitter between NREQ byte producers, e.g. a CPU-side AHB UART path, a debug/log source and a keyboard-event reporter.
- Sits between the requesters and UART_TX. Drives UART_TX's data/tx_en inputs and monitors its state (busy) output.
- Guarantees exactly one tx_en pulse per accepted byte, and never launches while the transmitter is busy.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NREQ.
- START_TO, 1024, cycles allowed between the tx_en pulse and tx_state rising before a timeout is declared (1..65535).

Ports:
- clk  input  1  system clock.
- RSTn  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  per-requester byte-available flag; must stay high with data stable until accepted.
- req_data  input  8*NREQ  requester i byte at [8*i+7:8*i].
- req_ready  output  NREQ  one-hot accept pulse; transfer occurs when req_valid[i] & req_ready[i].
- tx_data  output  8  byte to UART_TX.
- tx_en  output  1  single-cycle launch pulse to UART_TX.
- tx_state  input  1  UART_TX busy flag; high while a frame is shifting.
- grant_id  output  ID_W  index of the requester owning the current or last transfer.
- busy  output  1  high whenever the FSM is not in IDLE.
- timeout_err  output  1  single-cycle pulse when tx_state fails to rise within START_TO.

Behaviour:
- Reset values: req_ready=0, tx_data=0, tx_en=0, grant_id=0, busy=0, timeout_err=0. RR pointer = NREQ-1, so requester 0 has first priority. FSM = IDLE.
- Reset asserted mid-operation aborts immediately: no tx_en is issued and no pending req_ready pulse is produced. Any byte already launched completes inside UART_TX.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE:
  - When tx_state==0 and |req_valid, select the first valid requester searching ptr+1, ptr+2, ... modulo NREQ.
  - In the same cycle (combinational from registered ptr): req_ready[sel]=1 for exactly one cycle.
  - Registered on that edge: tx_data<=req_data[sel], grant_id<=sel, ptr<=sel. Next state LAUNCH.
  - If tx_state==1 in IDLE (busy from an external or earlier launch), no grant is made.
- LAUNCH: tx_en=1 for exactly one cycle; timeout counter cleared. Next state WAIT_START.
- WAIT_START:
  - tx_state==1 -> WAIT_DONE.
  - Counter reaches START_TO-1 with tx_state still 0 -> timeout_err pulse, then IDLE. The byte is dropped and not retried; ptr stays advanced.
- WAIT_DONE: tx_state==0 -> IDLE.
- tx_data is held stable from capture until the next grant.
- Minimum spacing between successive tx_en pulses is the full UART frame plus 2 cycles (WAIT_DONE->IDLE, IDLE->LAUNCH).
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...; no requester waits more than NREQ-1 transfers.
- Simultaneous events:
  - A requester dropping req_valid before acceptance is legal and simply loses that arbitration.
  - A req_valid rising in the grant cycle is considered only if it is combinationally present in that cycle.
- Indices >= NREQ are never granted. Counter is 16 bits and saturates conceptually at START_TO-1.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock [NREQ-1:0].
  - If req_lock[grant_id] is high at the cycle the FSM returns to IDLE and req_valid[grant_id] is high, that requester is granted again, bypassing round-robin. This sends multi-byte messages uninterrupted.
  - If that requester's req_valid is low, normal round-robin resumes from ptr+1.
  - A timeout clears the lock privilege for that transfer.
- When undefined: req_lock does not exist; pure round-robin.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5; model UART_TX raises tx_state 3 cycles after tx_en and holds it 100 cycles.
  -> req_ready=0001 for 1 cycle, tx_en one pulse the next cycle, tx_data=A5, grant_id=0, busy falls 1 cycle after tx_state falls.
- All four valid continuously with bytes 10,11,12,13.
  -> tx sequence 10,11,12,13,10; exactly one tx_en per frame; no tx_en while tx_state=1.
- tx_state held low forever after tx_en, START_TO=16.
  -> timeout_err pulses 16 cycles after the LAUNCH cycle; FSM returns to IDLE; next grant goes to the next requester in order.
- tx_state forced high in IDLE with req_valid=4'b0100.
  -> no req_ready and no tx_en until tx_state=0, then grant_id=2.
- RSTn asserted during WAIT_DONE.
  -> all outputs 0 asynchronously; after release, requester 0 wins over requester 3 when both are valid.
- UART_ARB_LOCK_EN defined, req_lock[1]=1, requesters 1 and 2 valid with 3 bytes queued on 1.
  -> three consecutive grants to 1, then grant to 2.
